bet_bank_ctrl: RTL

BET_BANK_CTRL -- requirements
Module: bet_bank_ctrl

---
 rtl/bet_bank_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/bet_bank_ctrl.sv
// bet_bank_ctrl: betting/bankroll controller with BET -> LOCKED -> SETTLE round flow.
// Optional macro BJ_PAYOUT_3_2_EN makes blackjack pay bet + floor(bet/2) instead of bet.
module bet_bank_ctrl #(
    parameter int MONEY_W    = 10,
    parameter int BET_W      = 7,
    parameter int START_BANK = 200,
    parameter int BET_MAX    = 99
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      increment_1,
    input  logic                      increment_5,
    input  logic                      increment_10,
    input  logic                      increment_25,
    input  logic                      bet_clear,
    input  logic                      deal,
    input  logic                      result_valid,
    input  logic [1:0]                result,
    output logic signed [MONEY_W-1:0] bank,
    output logic                      bank_neg,
    output logic [BET_W-1:0]          bet,
    output logic [1:0]                state,
    output logic                      round_done
);
    typedef enum logic [1:0] {ST_BET = 2'b00, ST_LOCKED = 2'b01, ST_SETTLE = 2'b10} state_t;
    localparam int SW = MONEY_W + 1;
    localparam int AW = BET_W + 2;

    state_t             state_q, state_d;
    logic [BET_W-1:0]   bet_q, bet_d, bet_sat;
    logic [MONEY_W-1:0] bank_q, bank_d, bank_sat;
    logic [1:0]         res_q, res_d;
    logic [3:0]         btn_q, rise;
    logic               done_q;
    logic [AW-1:0]      bet_sum;
    logic [SW-1:0]      pay, bank_sum;

    assign rise    = {increment_25, increment_10, increment_5, increment_1} & ~btn_q;
    assign bet_sum = AW'(bet_q) + (rise[0] ? AW'(1) : '0) + (rise[1] ? AW'(5) : '0)
                   + (rise[2] ? AW'(10) : '0) + (rise[3] ? AW'(25) : '0);
    assign bet_sat = (bet_sum > AW'(BET_MAX)) ? BET_W'(BET_MAX) : bet_sum[BET_W-1:0];

`ifdef BJ_PAYOUT_3_2_EN
    assign pay = {{(SW-BET_W){1'b0}}, bet_q}
               + ((res_q == 2'b11) ? {{(SW-BET_W+1){1'b0}}, bet_q[BET_W-1:1]} : '0);
`else
    assign pay = {{(SW-BET_W){1'b0}}, bet_q};
`endif

    // one extra bit of headroom: the top two bits disagree exactly on overflow
    assign bank_sum = {bank_q[MONEY_W-1], bank_q}
                    + ((res_q == 2'b00) ? -pay : (res_q == 2'b01) ? '0 : pay);
    assign bank_sat = (bank_sum[SW-1] != bank_sum[SW-2])
                    ? (bank_sum[SW-1] ? {1'b1, {(MONEY_W-1){1'b0}}} : {1'b0, {(MONEY_W-1){1'b1}}})
                    : bank_sum[MONEY_W-1:0];

    always_comb begin
        state_d = state_q;
        bet_d   = bet_q;
        bank_d  = bank_q;
        res_d   = res_q;
        case (state_q)
            ST_BET: begin
                bet_d = bet_clear ? '0 : bet_sat;
                if (deal && !bet_clear && bet_q != '0) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (result_valid) begin
                    res_d   = result;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                bank_d  = bank_sat;
                state_d = ST_BET;
            end
            default: state_d = ST_BET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BET;
            bet_q   <= '0;
            bank_q  <= MONEY_W'(START_BANK);
            res_q   <= 2'b00;
            btn_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bet_q   <= bet_d;
            bank_q  <= bank_d;
            res_q   <= res_d;
            btn_q   <= {increment_25, increment_10, increment_5, increment_1};
            done_q  <= (state_q == ST_SETTLE);
        end
    end

    assign bank       = bank_q;
    assign bank_neg   = bank_q[MONEY_W-1];
    assign bet        = bet_q;
    assign state      = state_q;
    assign round_done = done_q;
endmodule
